// File: rtl/branch_outcome_checker.sv
// branch_outcome_checker
//   Queues branch direction predictions in order and checks each one against
//   the actual outcome when it resolves. The result is fed back to the
//   predictor as a registered update pulse. Hit and miss statistics saturate.
//
// Ports
//   clk, reset_n              : clock, asynchronous active-low reset
//   pred_valid/pred_taken     : prediction offer (direction = counter MSB)
//   pred_ready                : prediction accepted when valid && ready
//   res_valid/res_taken       : actual outcome offer
//   res_ready                 : outcome accepted when valid && ready
//   flush                     : discard all outstanding predictions
//   clear_stats               : zero hit/miss counters
//   taken/update_valid/mispredict : registered predictor update
//   hit_count/miss_count      : saturating statistics
//   full/empty                : queue occupancy flags
module branch_outcome_checker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pred_valid,
  input  logic             pred_taken,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             res_ready,
  input  logic             flush,
  input  logic             clear_stats,
  output logic             taken,
  output logic             update_valid,
  output logic             mispredict,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic             update_valid_q, update_valid_d;
  logic             taken_q, taken_d;
  logic             mispredict_q, mispredict_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  logic push, pop, miss_now;

  assign full       = (occ_q == OCC_FULL);
  assign empty      = (occ_q == '0);
  assign pred_ready = !full;
  assign res_ready  = !empty;

  // Flush suppresses both handshakes so nothing is stored or resolved.
  assign push     = pred_valid && !full  && !flush;
  assign pop      = res_valid  && !empty && !flush;
  assign miss_now = (mem_q[rd_ptr_q] != res_taken);

  always_comb begin
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    occ_d          = occ_q;
    update_valid_d = 1'b0;
    taken_d        = taken_q;
    mispredict_d   = 1'b0;
    hit_d          = hit_q;
    miss_d         = miss_q;

    if (flush) begin
      rd_ptr_d       = '0;
      wr_ptr_d       = '0;
      occ_d          = '0;
      // The update outputs are frozen through a flush cycle.
      update_valid_d = update_valid_q;
      mispredict_d   = mispredict_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
      if (pop) begin
        update_valid_d = 1'b1;
        taken_d        = res_taken;
        mispredict_d   = miss_now;
      end
    end

    // clear_stats wins over a same-cycle increment.
    if (clear_stats) begin
      hit_d  = '0;
      miss_d = '0;
    end else if (pop) begin
      if (miss_now) begin
        if (miss_q != CNT_MAX) miss_d = miss_q + 1'b1;
      end else begin
        if (hit_q != CNT_MAX) hit_d = hit_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      occ_q          <= '0;
      update_valid_q <= 1'b0;
      taken_q        <= 1'b0;
      mispredict_q   <= 1'b0;
      hit_q          <= '0;
      miss_q         <= '0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      occ_q          <= occ_d;
      update_valid_q <= update_valid_d;
      taken_q        <= taken_d;
      mispredict_q   <= mispredict_d;
      hit_q          <= hit_d;
      miss_q         <= miss_d;
    end
  end

  // Entry storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pred_taken;
  end

  assign update_valid = update_valid_q;
  assign taken        = taken_q;
  assign mispredict   = mispredict_q;
  assign hit_count    = hit_q;
  assign miss_count   = miss_q;

endmodule

// File: tb/tb_branch_outcome_checker.sv
module tb_branch_outcome_checker;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pred_valid = 1'b0, pred_taken = 1'b0, pred_ready;
  logic res_valid = 1'b0, res_taken = 1'b0, res_ready;
  logic flush = 1'b0, clear_stats = 1'b0;
  logic taken, update_valid, mispredict, full, empty;
  logic [CNT_W-1:0] hit_count, miss_count;

  int compared = 0;
  int mismatched = 0;

  branch_outcome_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
    .flush(flush), .clear_stats(clear_stats),
    .taken(taken), .update_valid(update_valid), .mispredict(mispredict),
    .hit_count(hit_count), .miss_count(miss_count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_upd(input string tag, input logic uv, input logic tk, input logic mp);
    chk({tag, ".update_valid"}, 32'(update_valid), 32'(uv));
    chk({tag, ".taken"},        32'(taken),        32'(tk));
    chk({tag, ".mispredict"},   32'(mispredict),   32'(mp));
  endtask

  task automatic chk_cnt(input string tag, input int h, input int m);
    chk({tag, ".hit_count"},  32'(hit_count),  32'(h));
    chk({tag, ".miss_count"}, 32'(miss_count), 32'(m));
  endtask

  task automatic chk_occ(input string tag, input logic e, input logic f);
    chk({tag, ".empty"},      32'(empty),      32'(e));
    chk({tag, ".full"},       32'(full),       32'(f));
    chk({tag, ".res_ready"},  32'(res_ready),  32'(!e));
    chk({tag, ".pred_ready"}, 32'(pred_ready), 32'(!f));
  endtask

  task automatic push(input logic t);
    pred_valid = 1'b1; pred_taken = t;
    tick();
    pred_valid = 1'b0;
  endtask

  task automatic clr();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #2;
    chk_occ("rst", 1'b1, 1'b0);
    chk_upd("rst", 1'b0, 1'b0, 1'b0);
    chk_cnt("rst", 0, 0);
    #5 reset_n = 1'b1;
    tick();

    // In-order check: push T,T,N ; resolve T,N,N
    push(1'b1); push(1'b1); push(1'b0);
    chk_occ("io.after_push", 1'b0, 1'b0);
    chk_upd("io.idle", 1'b0, 1'b0, 1'b0);
    res_valid = 1'b1; res_taken = 1'b1; tick();
    chk_upd("io.r1", 1'b1, 1'b1, 1'b0); chk_cnt("io.r1", 1, 0);
    res_taken = 1'b0; tick();
    chk_upd("io.r2", 1'b1, 1'b0, 1'b1); chk_cnt("io.r2", 1, 1);
    res_taken = 1'b0; tick();
    chk_upd("io.r3", 1'b1, 1'b0, 1'b0); chk_cnt("io.r3", 2, 1);
    res_valid = 1'b0; tick();
    chk_upd("io.quiet", 1'b0, 1'b0, 1'b0);
    chk_occ("io.drained", 1'b1, 1'b0);

    // Full boundary: 5 back-to-back pushes 1,0,1,1,0
    clr();
    chk_cnt("full.clr", 0, 0);
    pred_valid = 1'b1;
    pred_taken = 1'b1; tick();
    pred_taken = 1'b0; tick();
    pred_taken = 1'b1; tick();
    chk_occ("full.p3", 1'b0, 1'b0);
    pred_taken = 1'b1; tick();
    chk_occ("full.p4", 1'b0, 1'b1);
    pred_taken = 1'b0; tick();
    chk_occ("full.p5", 1'b0, 1'b1);
    pred_valid = 1'b0;
    res_valid = 1'b1; res_taken = 1'b1;
    tick(); chk_upd("full.r1", 1'b1, 1'b1, 1'b0);
    tick(); chk_upd("full.r2", 1'b1, 1'b1, 1'b1);
    tick(); chk_upd("full.r3", 1'b1, 1'b1, 1'b0);
    tick(); chk_upd("full.r4", 1'b1, 1'b1, 1'b0);
    chk_cnt("full.r4", 3, 1);
    chk_occ("full.drained", 1'b1, 1'b0);
    tick();  // res_valid still high while empty: ignored
    chk_upd("full.extra", 1'b0, 1'b1, 1'b0);
    chk_cnt("full.extra", 3, 1);
    res_valid = 1'b0;

    // Simultaneous push/pop at occupancy 1 (older entry T, new entry N)
    clr();
    push(1'b1);
    pred_valid = 1'b1; pred_taken = 1'b0;
    res_valid = 1'b1;  res_taken = 1'b1;
    tick();
    pred_valid = 1'b0;
    chk_upd("sim.both", 1'b1, 1'b1, 1'b0);
    chk_occ("sim.occ1", 1'b0, 1'b0);
    res_taken = 1'b0; tick();
    chk_upd("sim.next", 1'b1, 1'b0, 1'b0);
    chk_cnt("sim.next", 2, 0);
    res_valid = 1'b0; tick();
    chk_occ("sim.drained", 1'b1, 1'b0);

    // Flush with res_valid high, 3 outstanding entries
    push(1'b1); push(1'b1); push(1'b1);
    flush = 1'b1; res_valid = 1'b1; res_taken = 1'b0;
    tick();
    flush = 1'b0;
    chk_upd("flush", 1'b0, 1'b0, 1'b0);
    chk_occ("flush", 1'b1, 1'b0);
    chk_cnt("flush", 2, 0);
    tick();
    chk_upd("flush.after", 1'b0, 1'b0, 1'b0);
    chk_cnt("flush.after", 2, 0);
    res_valid = 1'b0;

    // Saturation (CNT_W=2) and clear overriding a hit
    clr();
    push(1'b1);
    pred_valid = 1'b1; pred_taken = 1'b1;
    res_valid = 1'b1;  res_taken = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) pred_valid = 1'b0;
      tick();
      chk($sformatf("sat.hit%0d", i), 32'(hit_count), (i > 3) ? 32'd3 : 32'(i));
    end
    res_valid = 1'b0;
    chk_occ("sat.drained", 1'b1, 1'b0);
    push(1'b1);
    res_valid = 1'b1; clear_stats = 1'b1;
    tick();
    res_valid = 1'b0; clear_stats = 1'b0;
    chk_upd("sat.clr", 1'b1, 1'b1, 1'b0);
    chk_cnt("sat.clr", 0, 0);

    // Reset mid-operation
    push(1'b1); push(1'b1); push(1'b0);
    res_valid = 1'b1; res_taken = 1'b1; tick();
    res_valid = 1'b0;
    chk_upd("mid.pre", 1'b1, 1'b1, 1'b0);
    chk_cnt("mid.pre", 1, 0);
    #1 reset_n = 1'b0;
    #1;
    chk_occ("mid.rst", 1'b1, 1'b0);
    chk_upd("mid.rst", 1'b0, 1'b0, 1'b0);
    chk_cnt("mid.rst", 0, 0);
    #1 reset_n = 1'b1;
    tick();
    chk_occ("mid.released", 1'b1, 1'b0);
    push(1'b0);
    chk_occ("mid.push", 1'b0, 1'b0);
    res_valid = 1'b1; res_taken = 1'b0; tick();
    res_valid = 1'b0;
    chk_upd("mid.resolve", 1'b1, 1'b0, 1'b0);
    chk_cnt("mid.resolve", 1, 0);
    chk_occ("mid.end", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
